// File: rtl/cla_seq_add_ctrl_if.sv
// rtl/cla_seq_add_ctrl_if.sv - command/result handshake bundle for the sequential CLA adder (ovf member under CLA_SEQ_OVF_EN)
interface cla_seq_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             done_valid;
    logic             done_ready;
    logic             busy;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;

    modport master (
        output start_valid, a, b, cin, done_ready,
        input  start_ready, sum, cout, done_valid, busy, ovf
    );
    modport slave (
        input  start_valid, a, b, cin, done_ready,
        output start_ready, sum, cout, done_valid, busy, ovf
    );
`else
    modport master (
        output start_valid, a, b, cin, done_ready,
        input  start_ready, sum, cout, done_valid, busy
    );
    modport slave (
        input  start_valid, a, b, cin, done_ready,
        output start_ready, sum, cout, done_valid, busy
    );
`endif
endinterface

// File: rtl/cla_seq_add_ctrl.sv
// rtl/cla_seq_add_ctrl.sv - sequential adder reusing one 4-bit carry lookahead slice per clock; optional ovf via CLA_SEQ_OVF_EN
module cla_seq_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cla_seq_add_ctrl_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_valid_q, done_valid_d;
    logic             busy_q, busy_d;
    logic             start_ready_q, start_ready_d;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [IW+1:0]    bit_base;
    logic [3:0]       sa, sb, p, g, c;

    // Current slice operands and its 4-bit lookahead carries from the registered carry-in
    always_comb begin
        bit_base = {idx_q, 2'b00};
        sa = a_q[bit_base +: 4];
        sb = b_q[bit_base +: 4];
        p  = sa ^ sb;
        g  = sa & sb;
        c[0] = g[0] | (p[0] & carry_q);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carry_q);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry_q);
    end

    // Next-state and registered-output computation for IDLE/RUN/DONE sequencing
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        carry_d       = carry_q;
        a_d           = a_q;
        b_d           = b_q;
        sum_d         = sum_q;
        cout_d        = cout_q;
        done_valid_d  = done_valid_q;
        busy_d        = busy_q;
        start_ready_d = start_ready_q;
`ifdef CLA_SEQ_OVF_EN
        ovf_d         = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    state_d       = RUN;
                    a_d           = bus.a;
                    b_d           = bus.b;
                    carry_d       = bus.cin;
                    idx_d         = '0;
                    busy_d        = 1'b1;
                    start_ready_d = 1'b0;
                end
            end
            RUN: begin
                sum_d[bit_base +: 4] = p ^ {c[2:0], carry_q};
                carry_d              = c[3];
                if (idx_q == LAST_IDX) begin
                    idx_d        = '0;
                    state_d      = DONE;
                    cout_d       = c[3];
                    done_valid_d = 1'b1;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d        = c[3] ^ c[2];
`endif
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                // Result held until the consumer takes it; new commands are not queued
                if (bus.done_ready) begin
                    state_d       = IDLE;
                    done_valid_d  = 1'b0;
                    busy_d        = 1'b0;
                    start_ready_d = 1'b1;
                end
            end
            default: begin
                state_d       = IDLE;
                done_valid_d  = 1'b0;
                busy_d        = 1'b0;
                start_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            carry_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            sum_q         <= '0;
            cout_q        <= 1'b0;
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
            ovf_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            carry_q       <= carry_d;
            a_q           <= a_d;
            b_q           <= b_d;
            sum_q         <= sum_d;
            cout_q        <= cout_d;
            done_valid_q  <= done_valid_d;
            busy_q        <= busy_d;
            start_ready_q <= start_ready_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q         <= ovf_d;
`endif
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.sum         = sum_q;
    assign bus.cout        = cout_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.busy        = busy_q;
`ifdef CLA_SEQ_OVF_EN
    assign bus.ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// tb/tb_cla_seq_add_ctrl.sv - self-checking bench for cla_seq_add_ctrl (WIDTH=16, optional CLA_SEQ_OVF_EN)
module tb_cla_seq_add_ctrl;
    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    cla_seq_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cla_seq_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Arithmetic reference: {ovf, cout, sum} of a + b + cin
    function automatic logic [WIDTH+1:0] model_add(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic ci);
        logic [WIDTH:0] full;
        logic           v;
        full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        v    = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return {v, full};
    endfunction

    // Transaction-level model: an accepted command completes NSLICE edges later,
    // then the result is held until a done_ready edge
    logic             m_pending, m_done;
    int               m_cnt;
    logic [WIDTH-1:0] m_sum;
    logic             m_cout, m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0;
            m_done    <= 1'b0;
            m_cnt     <= 0;
        end else if (!m_pending && !m_done) begin
            if (bus.start_valid) begin
                m_pending                <= 1'b1;
                m_cnt                    <= 0;
                {m_ovf, m_cout, m_sum}   <= model_add(bus.a, bus.b, bus.cin);
            end
        end else if (m_pending) begin
            if (m_cnt == NSLICE - 1) begin
                m_pending <= 1'b0;
                m_done    <= 1'b1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (m_done && bus.done_ready) begin
            m_done <= 1'b0;
        end
    end

    // Compare process: handshake/status every cycle, result whenever valid
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_start_ready", bus.start_ready, !(m_pending || m_done));
            chk("model_busy", bus.busy, m_pending || m_done);
            chk("model_done_valid", bus.done_valid, m_done);
            if (m_done) begin
                chk("model_sum", bus.sum, m_sum);
                chk("model_cout", bus.cout, m_cout);
`ifdef CLA_SEQ_OVF_EN
                chk("model_ovf", bus.ovf, m_ovf);
`endif
            end
        end
    end

    task automatic wait_accept(input string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.start_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk({nm, "_accept"}, got, 1'b1);
        @(posedge clk);
    endtask

    task automatic wait_done(input string nm);
        int lat;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_valid) begin
                lat = i;
                break;
            end
        end
        chk({nm, "_latency"}, lat, NSLICE);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                          input int bp, input logic [15:0] exp_s, input logic exp_c,
                          input logic exp_o, input string nm);
        @(posedge clk);
        #2;
        bus.start_valid = 1'b1;
        bus.a           = ta;
        bus.b           = tb_v;
        bus.cin         = tcin;
        bus.done_ready  = 1'b0;
        wait_accept(nm);
        #2;
        bus.start_valid = 1'b0;
        bus.a           = 16'($urandom);
        bus.b           = 16'($urandom);
        bus.cin         = 1'($urandom);
        wait_done(nm);
        chk({nm, "_sum"}, bus.sum, exp_s);
        chk({nm, "_cout"}, bus.cout, exp_c);
        chk({nm, "_model_sum"}, m_sum, exp_s);
        chk({nm, "_model_cout"}, m_cout, exp_c);
`ifdef CLA_SEQ_OVF_EN
        chk({nm, "_ovf"}, bus.ovf, exp_o);
`else
        chk({nm, "_model_ovf"}, m_ovf, exp_o);
`endif
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #2;
            bus.start_valid = (i == 1 && bp >= 3);
            bus.a           = 16'h0001;
            chk({nm, "_bp_start_ready"}, bus.start_ready, 1'b0);
            chk({nm, "_bp_sum"}, bus.sum, exp_s);
        end
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b1;
        @(posedge clk);
        #2;
        bus.done_ready = 1'b0;
        chk({nm, "_post_done_valid"}, bus.done_valid, 1'b0);
        chk({nm, "_post_start_ready"}, bus.start_ready, 1'b1);
        chk({nm, "_post_sum"}, bus.sum, exp_s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total         = 0;
        n_pass          = 0;
        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.cin         = 1'b0;
        bus.done_ready  = 1'b0;
        #12;
        chk("rst_start_ready", bus.start_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done_valid", bus.done_valid, 1'b0);
        chk("rst_sum", bus.sum, 16'h0000);
        chk("rst_cout", bus.cout, 1'b0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0, "t_basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0, "t_ripple");
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000, 1'b1, 1'b0, "t_cin");
        run_op(16'h00AA, 16'h0055, 1'b0, 5, 16'h00FF, 1'b0, 1'b0, "t_backpressure");
`ifdef CLA_SEQ_OVF_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1, "t_ovf_pos");
        run_op(16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1, "t_ovf_neg");
        run_op(16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0, "t_ovf_none");
`endif

        // Back-to-back with start_valid held high across both commands
        @(posedge clk);
        #2;
        bus.start_valid = 1'b1;
        bus.a           = 16'h0F0F;
        bus.b           = 16'h00F1;
        bus.cin         = 1'b0;
        bus.done_ready  = 1'b1;
        wait_accept("t_b2b1");
        #2;
        bus.a = 16'h8000;
        bus.b = 16'h8000;
        wait_done("t_b2b1");
        chk("t_b2b1_sum", bus.sum, 16'h1000);
        chk("t_b2b1_cout", bus.cout, 1'b0);
        @(posedge clk);
        #1;
        chk("t_b2b_hs_done_valid", bus.done_valid, 1'b0);
        chk("t_b2b_hs_idle_busy", bus.busy, 1'b0);
        chk("t_b2b_hs_start_ready", bus.start_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("t_b2b2_accept_busy", bus.busy, 1'b1);
        chk("t_b2b2_accept_start_ready", bus.start_ready, 1'b0);
        #1;
        bus.start_valid = 1'b0;
        wait_done("t_b2b2");
        chk("t_b2b2_sum", bus.sum, 16'h0000);
        chk("t_b2b2_cout", bus.cout, 1'b1);
        @(posedge clk);
        #2;
        bus.done_ready = 1'b0;

        // Asynchronous reset while two slices into an operation
        @(posedge clk);
        #2;
        bus.start_valid = 1'b1;
        bus.a           = 16'hFFFF;
        bus.b           = 16'hFFFF;
        bus.cin         = 1'b1;
        wait_accept("t_abort");
        #2;
        bus.start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t_abort_start_ready", bus.start_ready, 1'b1);
        chk("t_abort_busy", bus.busy, 1'b0);
        chk("t_abort_done_valid", bus.done_valid, 1'b0);
        chk("t_abort_sum", bus.sum, 16'h0000);
        chk("t_abort_cout", bus.cout, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        run_op(16'h0003, 16'h0004, 1'b0, 0, 16'h0007, 1'b0, 1'b0, "t_after_abort");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
